// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with fill level, thresholds, FWFT and sticky errors
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_err;
    logic              rd_err;

    // Flags derive only from registered pointers, so requests never reach them combinationally.
    assign count        = wptr - rptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = w_en && !full && !flush;
    assign rd_acc = r_en && !empty && !flush;
    assign wr_err = w_en && full && !flush;
    assign rd_err = r_en && empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_err)       overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (rd_err)        underflow <= 1'b1;
            else if (clr_err)  underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rptr[ADDR_W-1:0]];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rptr[ADDR_W-1:0]];
                end
            end
            assign data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (standard and FWFT instances)
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_en, r_en, flush, clr_err;
    logic [7:0] data_in;

    logic [7:0] data_out, f_data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];
    logic [7:0] exp_v;
    logic [7:0] next_v;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .flush(flush), .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .flush(flush), .clr_err(clr_err), .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;
        #12;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ae", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        check("rst_dout", data_out, 0);
        rst_n = 1'b1;

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            tick();
            check("fill_count", count, i + 1);
            check("fill_af", almost_full, (i + 1) >= 12);
            check("fill_ae", almost_empty, (i + 1) <= 4);
            check("fill_full", full, (i + 1) == 16);
        end
        data_in = 8'hFF;
        tick();
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        w_en = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", overflow, 0);

        // drain in standard mode
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            tick();
            check("drain_dout", data_out, i);
            check("drain_count", count, 15 - i);
        end
        check("drain_empty", empty, 1);
        tick();
        check("udf_set", underflow, 1);
        check("udf_hold", data_out, 8'h0F);
        r_en = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("udf_clr", underflow, 0);

        // steady state at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; data_in = 8'(8'h20 + i); q.push_back(data_in);
            tick();
        end
        next_v = 8'h28;
        for (int i = 0; i < 40; i++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = next_v;
            tick();
            exp_v = q.pop_front();
            q.push_back(next_v);
            next_v++;
            check("bb_dout", data_out, exp_v);
            check("bb_count", count, 8);
        end
        r_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_in = next_v; q.push_back(next_v); next_v++;
            tick();
        end
        check("bb_full", full, 1);
        r_en = 1'b1; data_in = 8'hEE;
        tick();
        exp_v = q.pop_front();
        check("fullrw_count", count, 15);
        check("fullrw_ovf", overflow, 1);
        check("fullrw_dout", data_out, exp_v);
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // flush at count 10 with both requests high
        for (int i = 0; i < 5; i++) begin
            r_en = 1'b1;
            tick();
            exp_v = q.pop_front();
            check("pre_flush_dout", data_out, exp_v);
        end
        check("pre_flush_count", count, 10);
        flush = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'h77;
        tick();
        flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_ovf", overflow, 0);
        check("flush_udf", underflow, 0);
        check("flush_dout", data_out, exp_v);
        q.delete();

        // first-word fall-through
        w_en = 1'b1; data_in = 8'hA5;
        tick();
        w_en = 1'b0;
        check("fwft_dout", f_data_out, 8'hA5);
        check("fwft_empty", f_empty, 0);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("fwft_pop_empty", f_empty, 1);
        check("std_pop_dout", data_out, 8'hA5);

        // error set beats concurrent clear
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; data_in = 8'(8'h50 + i);
            tick();
        end
        clr_err = 1'b1;
        tick();
        check("ovf_vs_clr", overflow, 1);
        w_en = 1'b0;
        tick();
        clr_err = 1'b0;
        check("ovf_clr2", overflow, 0);

        // asynchronous reset between edges
        w_en = 1'b1; r_en = 1'b1;
        tick();
        tick();
        check("pre_rst_ovf", overflow, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_af", almost_full, 0);
        check("arst_ae", almost_empty, 1);
        check("arst_dout", data_out, 0);
        check("arst_ovf", overflow, 0);
        check("arst_udf", underflow, 0);
        w_en = 1'b0; r_en = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for buffering within one clock domain; the same-domain counterpart of the team's dual-clock Gray-pointer FIFO. Adds configurable width and depth, fill count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through read mode, synchronous flush, and sticky overflow/underflow error flags. Used between producer/consumer stages that share a clock.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W words
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range AE_LEVEL < AF_LEVEL <= DEPTH
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; legal range 0 <= AE_LEVEL < AF_LEVEL
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- w_en  input  1  write request
- data_in  input  DATA_W  write data
- r_en  input  1  read request (FWFT=1: pop/acknowledge of data_out)
- flush  input  1  synchronous clear of FIFO contents
- clr_err  input  1  synchronous clear of sticky error flags
- data_out  output  DATA_W  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  ADDR_W+1  words currently stored, 0..DEPTH
- overflow  output  1  sticky: write requested while full
- underflow  output  1  sticky: read requested while empty

## Operation
- Storage: DEPTH x DATA_W register array, not reset.
- Pointers wptr, rptr: ADDR_W+1 bits binary; low ADDR_W bits address storage, MSB is wrap bit. Increment modulo 2^(ADDR_W+1).
- count = wptr - rptr, ADDR_W+1 bits modulo arithmetic; full/empty/almost flags decode from count only.
- Write accepted iff w_en && !full && !flush: store data_in at wptr, wptr+1.
- Read accepted iff r_en && !empty && !flush: rptr+1.
- Simultaneous read/write, neither flag set: both accepted, count unchanged.
- Full with w_en && r_en: read accepted, write rejected, overflow set.
- Empty with w_en && r_en: write accepted, read rejected, underflow set.
- FWFT=0: on accepted read, data_out loads storage[rptr] at that edge; otherwise holds.
- FWFT=1: data_out = storage[rptr] continuously; valid whenever !empty; value when empty is don't-care.
- flush: at edge, wptr = rptr = 0; w_en/r_en in the same cycle are ignored and raise no error; storage, data_out (FWFT=0) and sticky flags unaffected.
- overflow/underflow: set on the offending edge, cleared by clr_err; set has priority over clr_err in the same cycle. Rejected requests change no other state.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert by system): wptr = rptr = 0, data_out = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
- All flags and count reflect registered pointers: updated in the cycle after the accepting edge; no combinational path from w_en/r_en to any flag.
- Write-to-read latency: word written at edge k is readable from cycle k+1 (empty falls after edge k).
- FWFT=0 read latency: data_out valid after the accepting edge (1 cycle).
- FWFT=1: head word on data_out in cycle after write into empty FIFO; next word appears the cycle after each pop.
- Back-to-back: one write and one read per cycle sustained indefinitely with count constant.
- Wrap: pointers cross DEPTH-1 -> 0 without bubble; full/empty distinguished by MSB via count.
- Reset mid-operation: all state returns to reset values immediately; contents discarded.

## Test plan
- Reset then write 16 words 0x00..0x0F (defaults) -> count 16, full = 1, almost_full from count 12, almost_empty clears at count 5; 17th write -> overflow = 1, count stays 16.
- FWFT=0: read 16 words -> data_out 0x00..0x0F, each one cycle after its read edge; empty = 1 after the last; extra read -> underflow = 1, data_out holds 0x0F.
- Simultaneous w_en/r_en for 40 cycles at count 8 -> count constant 8, data order preserved across pointer wrap; at full with both asserted -> count 15, overflow = 1.
- FWFT=1: write 0xA5 into empty FIFO -> data_out = 0xA5, empty = 0 next cycle; pop -> empty = 1.
- flush at count 10 with w_en/r_en high -> count 0, empty = 1, no error set; clr_err with concurrent overflow event -> overflow remains 1.
- Assert rst_n low mid-stream between clock edges -> all outputs at reset values immediately, before next clk edge.
